// File: rtl/spider_hit_detector.sv
// spider_hit_detector: per-frame collision resolver for the four spiders.
// Snapshots every input at the start of a frame. It then scans one spider per
// cycle and emits registered one-cycle strobes plus a saturating score.
module spider_hit_detector #(
  parameter int SPIDER_W    = 32,
  parameter int SPIDER_H    = 32,
  parameter int BULLET_W    = 4,
  parameter int BULLET_H    = 8,
  parameter int PLAYER_W    = 32,
  parameter int PLAYER_H    = 32,
  parameter int KILL_POINTS = 10
) (
  input  logic        clk25,
  input  logic        reset_spider,
  input  logic        frame_tick,
  input  logic [39:0] spider_x_flat,
  input  logic [39:0] spider_y_flat,
  input  logic [3:0]  spider_alive_flat,
  input  logic [9:0]  bullet_x,
  input  logic [9:0]  bullet_y,
  input  logic        bullet_active,
  input  logic [9:0]  player_x,
  input  logic [9:0]  player_y,
  output logic [3:0]  spider_kill,
  output logic        bullet_consume,
  output logic        player_hit,
  output logic [15:0] score,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SNAP, SCAN, REPORT} state_t;

  localparam logic [10:0] SW = 11'(SPIDER_W);
  localparam logic [10:0] SH = 11'(SPIDER_H);
  localparam logic [10:0] BW = 11'(BULLET_W);
  localparam logic [10:0] BH = 11'(BULLET_H);
  localparam logic [10:0] PW = 11'(PLAYER_W);
  localparam logic [10:0] PH = 11'(PLAYER_H);

  state_t      r_state, w_next;
  logic [1:0]  r_idx;
  logic [39:0] r_sx, r_sy;
  logic [3:0]  r_alive;
  logic [9:0]  r_bx, r_by, r_px, r_py;
  logic        r_bact;
  logic [3:0]  r_kill_acc;
  logic        r_bused, r_pacc;
  logic [3:0]  r_kill;
  logic        r_consume, r_phit, r_busy;
  logic [15:0] r_score;

  logic [10:0] w_sx, w_sy, w_bx, w_by, w_px, w_py;
  logic        w_alive, w_bov, w_pov, w_bhit, w_phit, w_last;
  logic [3:0]  w_kill_nxt;
  logic        w_bused_nxt, w_pacc_nxt;
  logic [2:0]  w_pop;
  logic [31:0] w_sum;
  logic [15:0] w_score_nxt;

  // Select the snapped spider under test; all sums are 11 bits so the right
  // and bottom edges never wrap past 1023.
  always_comb begin
    w_sx    = '0;
    w_sy    = '0;
    w_alive = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (r_idx == i[1:0]) begin
        w_sx    = {1'b0, r_sx[i*10 +: 10]};
        w_sy    = {1'b0, r_sy[i*10 +: 10]};
        w_alive = r_alive[i];
      end
    end
  end

  assign w_bx = {1'b0, r_bx};
  assign w_by = {1'b0, r_by};
  assign w_px = {1'b0, r_px};
  assign w_py = {1'b0, r_py};

  assign w_bov = (w_sx < w_bx + BW) && (w_bx < w_sx + SW) &&
                 (w_sy < w_by + BH) && (w_by < w_sy + SH);
  assign w_pov = (w_sx < w_px + PW) && (w_px < w_sx + SW) &&
                 (w_sy < w_py + PH) && (w_py < w_sy + SH);

  // The bullet is spent by the first (lowest index) spider it hits. A spider
  // killed on this cycle cannot also hurt the player.
  assign w_bhit = (r_state == SCAN) && w_alive && r_bact && w_bov && !r_bused;
  assign w_phit = (r_state == SCAN) && w_alive && w_pov && !w_bhit;
  assign w_last = (r_state == SCAN) && (r_idx == 2'd3);

  assign w_kill_nxt  = r_kill_acc | ({3'b000, w_bhit} << r_idx);
  assign w_bused_nxt = r_bused | w_bhit;
  assign w_pacc_nxt  = r_pacc | w_phit;

  // Score increment from the final kill mask, saturating at 16'hFFFF.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < 4; i++) w_pop = w_pop + 3'(w_kill_nxt[i]);
    w_sum       = 32'(r_score) + 32'(w_pop) * 32'(KILL_POINTS);
    w_score_nxt = (w_sum > 32'h0000_FFFF) ? 16'hFFFF : w_sum[15:0];
  end

  // Next-state: frame_tick is only honoured in IDLE, so ticks while busy drop.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (frame_tick) w_next = SNAP;
      SNAP:    w_next = SCAN;
      SCAN:    if (r_idx == 2'd3) w_next = REPORT;
      REPORT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk25 or posedge reset_spider) begin
    if (reset_spider) r_state <= IDLE;
    else              r_state <= w_next;
  end

  // Snapshot, scan accumulators and registered outputs. Strobes load on the
  // last scan cycle so they are visible for exactly the REPORT cycle.
  always_ff @(posedge clk25 or posedge reset_spider) begin
    if (reset_spider) begin
      r_idx      <= '0;
      r_sx       <= '0;
      r_sy       <= '0;
      r_alive    <= '0;
      r_bx       <= '0;
      r_by       <= '0;
      r_bact     <= 1'b0;
      r_px       <= '0;
      r_py       <= '0;
      r_kill_acc <= '0;
      r_bused    <= 1'b0;
      r_pacc     <= 1'b0;
      r_kill     <= '0;
      r_consume  <= 1'b0;
      r_phit     <= 1'b0;
      r_score    <= '0;
      r_busy     <= 1'b0;
    end else begin
      if (r_state == SNAP) begin
        r_sx       <= spider_x_flat;
        r_sy       <= spider_y_flat;
        r_alive    <= spider_alive_flat;
        r_bx       <= bullet_x;
        r_by       <= bullet_y;
        r_bact     <= bullet_active;
        r_px       <= player_x;
        r_py       <= player_y;
        r_kill_acc <= '0;
        r_bused    <= 1'b0;
        r_pacc     <= 1'b0;
        r_idx      <= '0;
      end else if (r_state == SCAN) begin
        r_kill_acc <= w_kill_nxt;
        r_bused    <= w_bused_nxt;
        r_pacc     <= w_pacc_nxt;
        r_idx      <= r_idx + 2'd1;
      end
      r_kill    <= w_last ? w_kill_nxt  : 4'b0000;
      r_consume <= w_last ? w_bused_nxt : 1'b0;
      r_phit    <= w_last ? w_pacc_nxt  : 1'b0;
      if (w_last) r_score <= w_score_nxt;
      r_busy <= (w_next != IDLE);
    end
  end

  assign spider_kill    = r_kill;
  assign bullet_consume = r_consume;
  assign player_hit     = r_phit;
  assign score          = r_score;
  assign busy           = r_busy;

endmodule

// File: tb/tb_spider_hit_detector.sv
// Scoreboard bench for spider_hit_detector: the stimulus side pushes the
// expected frame result, and a monitor pops it when the DUT reports.
module tb_spider_hit_detector;

  localparam int SW = 32, SH = 32, BW = 4, BH = 8, PW = 32, PH = 32, KP = 10;

  typedef struct packed {
    logic [3:0]  k;
    logic        c;
    logic        p;
    logic [15:0] s;
  } exp_t;

  logic        clk25 = 1'b0;
  logic        reset_spider;
  logic        frame_tick;
  logic [39:0] spider_x_flat, spider_y_flat;
  logic [3:0]  spider_alive_flat;
  logic [9:0]  bullet_x, bullet_y, player_x, player_y;
  logic        bullet_active;
  logic [3:0]  spider_kill;
  logic        bullet_consume, player_hit, busy;
  logic [15:0] score;

  int   n_cmp = 0;
  int   n_err = 0;
  int   m_score = 0;
  exp_t sb[$];

  spider_hit_detector #(
    .SPIDER_W(SW), .SPIDER_H(SH), .BULLET_W(BW), .BULLET_H(BH),
    .PLAYER_W(PW), .PLAYER_H(PH), .KILL_POINTS(KP)
  ) dut (
    .clk25(clk25), .reset_spider(reset_spider), .frame_tick(frame_tick),
    .spider_x_flat(spider_x_flat), .spider_y_flat(spider_y_flat),
    .spider_alive_flat(spider_alive_flat),
    .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_active(bullet_active),
    .player_x(player_x), .player_y(player_y),
    .spider_kill(spider_kill), .bullet_consume(bullet_consume),
    .player_hit(player_hit), .score(score), .busy(busy)
  );

  always #20 clk25 = ~clk25;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ovl(int ax, int ay, int aw, int ah, int bx, int by, int bw, int bh);
    return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
  endfunction

  // Reference: walk spiders in index order; the bullet is spent by the first
  // live spider it touches; any other live spider touching the player hurts.
  function automatic exp_t model(input logic [39:0] sx, sy, input logic [3:0] al,
                                 input logic [9:0] bx, by, input logic ba,
                                 input logic [9:0] px, py);
    exp_t e;
    bit   used;
    int   x, y;
    e = '0;
    used = 0;
    for (int i = 0; i < 4; i++) begin
      x = int'(sx[i*10 +: 10]);
      y = int'(sy[i*10 +: 10]);
      if (al[i] && ba && !used && ovl(x, y, SW, SH, int'(bx), int'(by), BW, BH)) begin
        e.k[i] = 1'b1;
        used = 1;
      end
      if (al[i] && !e.k[i] && ovl(x, y, SW, SH, int'(px), int'(py), PW, PH)) e.p = 1'b1;
    end
    e.c = used;
    return e;
  endfunction

  function automatic logic [39:0] pk(input logic [9:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // mode 0: plain frame; 1: extra tick before edge T+3; 2: reset across edge T+4.
  task automatic run_frame(input logic [39:0] sx, sy, input logic [3:0] al,
                           input logic [9:0] bx, by, input logic ba,
                           input logic [9:0] px, py, input int mode);
    exp_t e;
    spider_x_flat = sx; spider_y_flat = sy; spider_alive_flat = al;
    bullet_x = bx; bullet_y = by; bullet_active = ba;
    player_x = px; player_y = py;
    e = model(sx, sy, al, bx, by, ba, px, py);
    if (mode != 2) begin
      m_score = m_score + KP * $countones(e.k);
      if (m_score > 65535) m_score = 65535;
      e.s = 16'(m_score);
      sb.push_back(e);
    end
    frame_tick = 1'b1;
    @(posedge clk25); #1 frame_tick = 1'b0;               // past T
    @(posedge clk25); #1;                                  // past T+1 (snapshot taken)
    spider_x_flat = {8'($urandom), $urandom};
    spider_y_flat = {8'($urandom), $urandom};
    spider_alive_flat = 4'($urandom);
    bullet_x = 10'($urandom); bullet_y = 10'($urandom);
    bullet_active = 1'($urandom);
    player_x = 10'($urandom); player_y = 10'($urandom);
    @(posedge clk25); #1;                                  // past T+2
    if (mode == 1) frame_tick = 1'b1;
    @(posedge clk25); #1 frame_tick = 1'b0;               // past T+3
    if (mode == 2) begin
      reset_spider = 1'b1;
      m_score = 0;
    end
    @(posedge clk25); #1 reset_spider = 1'b0;             // past T+4
    @(posedge clk25); #1;                                  // past T+5
    @(posedge clk25); #1;                                  // past T+6
  endtask

  // Monitor: a report is the sixth busy cycle; it is checked when busy falls.
  initial begin : monitor
    int          bcnt;
    logic        pb;
    exp_t        e;
    logic [3:0]  sk;
    logic        sc, sp;
    logic [15:0] ss;
    bcnt = 0; pb = 1'b0; sk = '0; sc = 1'b0; sp = 1'b0; ss = '0;
    forever begin
      @(negedge clk25);
      if (reset_spider) begin
        bcnt = 0;
        pb   = 1'b0;
        chk("rst_outputs", {11'b0, spider_kill, bullet_consume, player_hit, busy, score},
            32'h0);
      end else begin
        if (busy) begin
          bcnt++;
          if (bcnt == 6) begin
            sk = spider_kill; sc = bullet_consume; sp = player_hit; ss = score;
          end
        end
        if (!(busy && bcnt == 6))
          chk("strobe_outside_report", {29'b0, spider_kill != 4'b0, bullet_consume, player_hit},
              32'h0);
        if (!busy && pb) begin
          chk("busy_len", bcnt, 6);
          if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_report: got kill=%b with no frame pending", sk);
          end else begin
            e = sb.pop_front();
            chk("spider_kill", 32'(sk), 32'(e.k));
            chk("bullet_consume", 32'(sc), 32'(e.c));
            chk("player_hit", 32'(sp), 32'(e.p));
            chk("score", 32'(ss), 32'(e.s));
          end
          bcnt = 0;
        end
        pb = busy;
      end
    end
  end

  localparam logic [9:0] FAR = 10'd900;

  initial begin : stim
    logic [9:0] bxr, byr, base_x, base_y;
    logic [9:0] xs[4], ys[4];
    reset_spider = 1'b1; frame_tick = 1'b0;
    spider_x_flat = '0; spider_y_flat = '0; spider_alive_flat = '0;
    bullet_x = '0; bullet_y = '0; bullet_active = 1'b0;
    player_x = '0; player_y = '0;
    repeat (3) @(posedge clk25);
    #1 reset_spider = 1'b0;
    repeat (3) @(posedge clk25);
    #1;
    chk("post_reset_score", 32'(score), 32'h0);
    chk("post_reset_busy", 32'(busy), 32'h0);

    // Single kill on spider 2.
    run_frame(pk(0, 100, 448, 200), pk(500, 500, 100, 500), 4'b1111,
              460, 120, 1, FAR, FAR, 0);
    chk("score_after_kill", 32'(score), 32'd10);
    // Overlap priority: lowest index wins.
    run_frame(pk(100, 100, 600, 700), pk(100, 100, 600, 700), 4'b1111,
              110, 110, 1, FAR, FAR, 0);
    // Edge exclusivity then edge hit.
    run_frame(pk(0, 300, 400, 500), pk(0, 300, 400, 500), 4'b1111, 32, 0, 1, FAR, FAR, 0);
    run_frame(pk(0, 300, 400, 500), pk(0, 300, 400, 500), 4'b1111, 31, 0, 1, FAR, FAR, 0);
    // Player hit vs kill, and dead spider.
    run_frame(pk(0, 40, 80, 300), pk(0, 0, 0, 440), 4'b1111, 0, 900, 0, 310, 448, 0);
    run_frame(pk(0, 40, 80, 300), pk(0, 0, 0, 440), 4'b1111, 305, 445, 1, 310, 448, 0);
    run_frame(pk(0, 40, 80, 300), pk(0, 0, 0, 440), 4'b0111, 305, 445, 1, 310, 448, 0);
    // Far corner: 11-bit sums keep the box edges from wrapping.
    run_frame(pk(1010, 0, 0, 0), pk(1010, 0, 0, 0), 4'b0001, 1020, 1020, 1, 1000, 1000, 0);
    // Ignored tick while busy.
    run_frame(pk(0, 100, 448, 200), pk(500, 500, 100, 500), 4'b1111,
              460, 120, 1, FAR, FAR, 1);

    // Randomized clustered frames.
    for (int n = 0; n < 300; n++) begin
      base_x = 10'($urandom_range(0, 960));
      base_y = 10'($urandom_range(0, 960));
      for (int i = 0; i < 4; i++) begin
        xs[i] = base_x + 10'($urandom_range(0, 60));
        ys[i] = base_y + 10'($urandom_range(0, 60));
      end
      bxr = base_x + 10'($urandom_range(0, 63));
      byr = base_y + 10'($urandom_range(0, 63));
      run_frame(pk(xs[0], xs[1], xs[2], xs[3]), pk(ys[0], ys[1], ys[2], ys[3]),
                4'($urandom), bxr, byr, 1'($urandom_range(0, 3) != 0),
                base_x + 10'($urandom_range(0, 63)), base_y + 10'($urandom_range(0, 63)),
                ($urandom_range(0, 7) == 0) ? 1 : 0);
    end

    // Reset mid-scan: no report, score cleared.
    run_frame(pk(0, 100, 448, 200), pk(500, 500, 100, 500), 4'b1111,
              460, 120, 1, FAR, FAR, 2);
    chk("score_after_abort", 32'(score), 32'h0);
    chk("queue_after_abort", sb.size(), 0);

    // Drive score to 65530 with kills, then one more kill saturates.
    for (int n = 0; n < 6553; n++)
      run_frame(pk(0, 100, 448, 200), pk(500, 500, 100, 500), 4'b1111,
                460, 120, 1, FAR, FAR, 0);
    chk("score_preload", 32'(score), 32'd65530);
    run_frame(pk(0, 100, 448, 200), pk(500, 500, 100, 500), 4'b1111,
              460, 120, 1, FAR, FAR, 0);
    chk("score_saturate", 32'(score), 32'd65535);
    run_frame(pk(0, 100, 448, 200), pk(500, 500, 100, 500), 4'b1111,
              460, 120, 1, FAR, FAR, 0);
    chk("score_hold", 32'(score), 32'd65535);

    repeat (4) @(posedge clk25);
    #1;
    chk("queue_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
